// File: rtl/alu_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : alu_addsub_seq
// Description : Multi-cycle add/sub (ADD/SUB/ADC/SBB) that processes CHUNK
//               bits per clock through a registered carry, with optional
//               signed saturation, start/done handshake and NZCV-style flags.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_addsub_seq #(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sat,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] result,
   output logic             carry,
   output logic             overflow,
   output logic             zero,
   output logic             negative
);

   localparam int N    = WIDTH / CHUNK;
   localparam int IDXW = (N > 1) ? $clog2(N) : 1;

   localparam logic [IDXW-1:0]  c_LAST_IDX = IDXW'(N - 1);
   localparam logic [WIDTH-1:0] c_MAXPOS   = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_MINNEG   = {1'b1, {(WIDTH-1){1'b0}}};

   localparam logic [0:0] c_IDLE = 1'b0;
   localparam logic [0:0] c_RUN  = 1'b1;

   logic [0:0]       r_state;
   logic [0:0]       w_state_next;
   logic             w_accept;
   logic             w_last;

   // Operands are shifted right one chunk per cycle so the live chunk is
   // always at bit 0; the sign bits needed for overflow are kept separately.
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_raw;
   logic             r_op0;
   logic             r_sat;
   logic             r_amsb;
   logic             r_bmsb;
   logic             r_c;
   logic [IDXW-1:0]  r_idx;

   logic [CHUNK-1:0] w_sum;
   logic             w_cc;
   logic [WIDTH-1:0] w_sum_ext;
   logic [WIDTH-1:0] w_raw_next;
   logic             w_ovf;
   logic [WIDTH-1:0] w_res;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic: IDLE -> RUN on start, RUN -> IDLE after last chunk
   always_comb begin
      w_state_next = r_state;
      case (r_state)
         c_IDLE:  if (start)  w_state_next = c_RUN;
         c_RUN:   if (w_last) w_state_next = c_IDLE;
         default: w_state_next = c_IDLE;
      endcase
   end

   // FSM outputs: busy flag, accept strobe, last-chunk strobe
   always_comb begin
      busy     = (r_state == c_RUN);
      w_accept = (r_state == c_IDLE) && start;
      w_last   = (r_state == c_RUN) && (r_idx == c_LAST_IDX);
   end

   // One chunk of the ripple add, and the final result/overflow/saturation
   always_comb begin
      {w_cc, w_sum} = {1'b0, r_a[CHUNK-1:0]} + {1'b0, r_b[CHUNK-1:0]}
                    + {{CHUNK{1'b0}}, r_c};
      w_sum_ext     = WIDTH'(w_sum);
      // New chunk enters at the top; after N cycles the sum is in place.
      w_raw_next    = (r_raw >> CHUNK) | (w_sum_ext << (WIDTH - CHUNK));
      w_ovf         = (r_amsb == r_bmsb) && (w_raw_next[WIDTH-1] != r_amsb);
      w_res         = (r_sat && w_ovf) ? (r_amsb ? c_MINNEG : c_MAXPOS)
                                       : w_raw_next;
   end

   // Datapath: latch operands on accept, step chunks, publish on completion
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_a      <= '0;
         r_b      <= '0;
         r_raw    <= '0;
         r_op0    <= 1'b0;
         r_sat    <= 1'b0;
         r_amsb   <= 1'b0;
         r_bmsb   <= 1'b0;
         r_c      <= 1'b0;
         r_idx    <= '0;
         done     <= 1'b0;
         result   <= '0;
         carry    <= 1'b0;
         overflow <= 1'b0;
         zero     <= 1'b0;
         negative <= 1'b0;
      end else begin
         done <= w_last;
         if (w_accept) begin
            r_a    <= a;
            r_b    <= b ^ {WIDTH{op[0]}};
            r_op0  <= op[0];
            r_sat  <= sat;
            r_amsb <= a[WIDTH-1];
            r_bmsb <= b[WIDTH-1] ^ op[0];
            // Initial carry: ADD 0, SUB 1, ADC cin, SBB ~cin
            r_c    <= op[1] ? (cin ^ op[0]) : op[0];
            r_idx  <= '0;
            r_raw  <= '0;
         end else if (busy) begin
            r_a   <= r_a >> CHUNK;
            r_b   <= r_b >> CHUNK;
            r_raw <= w_raw_next;
            r_c   <= w_cc;
            r_idx <= r_idx + IDXW'(1);
            if (w_last) begin
               r_idx    <= '0;
               result   <= w_res;
               carry    <= w_cc ^ r_op0;
               overflow <= w_ovf;
               zero     <= (w_res == '0);
               negative <= w_res[WIDTH-1];
            end
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_alu_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_addsub_seq
// Description : Self-checking bench for alu_addsub_seq. Three instances
//               (16/4, 32/8, 8/8) share stimulus and are compared against a
//               plain-integer arithmetic model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_addsub_seq;

   localparam logic [1:0] c_ADD = 2'b00;
   localparam logic [1:0] c_SUB = 2'b01;
   localparam logic [1:0] c_ADC = 2'b10;
   localparam logic [1:0] c_SBB = 2'b11;

   typedef struct packed {
      logic [31:0] res;
      logic        carry;
      logic        ovf;
      logic        zero;
      logic        neg;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [2:0]  start;
   logic [1:0]  op;
   logic [31:0] a_drv;
   logic [31:0] b_drv;
   logic        cin;
   logic        sat;

   logic [2:0]  busy, done, carry, ovf, zero, neg;
   logic [15:0] r0;
   logic [31:0] r1;
   logic [7:0]  r2;
   logic [31:0] res [3];

   int          checks = 0;
   int          errors = 0;
   int          wid [3]     = '{16, 32, 8};
   int          lat_exp [3] = '{5, 5, 2};
   logic [31:0] prev_res [3];

   assign res[0] = {16'd0, r0};
   assign res[1] = r1;
   assign res[2] = {24'd0, r2};

   always #5 clk = ~clk;

   alu_addsub_seq #(.WIDTH(16), .CHUNK(4)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .start(start[0]), .op(op),
      .a(a_drv[15:0]), .b(b_drv[15:0]), .cin(cin), .sat(sat),
      .busy(busy[0]), .done(done[0]), .result(r0), .carry(carry[0]),
      .overflow(ovf[0]), .zero(zero[0]), .negative(neg[0]));

   alu_addsub_seq #(.WIDTH(32), .CHUNK(8)) u_dut32 (
      .clk(clk), .rst_n(rst_n), .start(start[1]), .op(op),
      .a(a_drv), .b(b_drv), .cin(cin), .sat(sat),
      .busy(busy[1]), .done(done[1]), .result(r1), .carry(carry[1]),
      .overflow(ovf[1]), .zero(zero[1]), .negative(neg[1]));

   alu_addsub_seq #(.WIDTH(8), .CHUNK(8)) u_dut8 (
      .clk(clk), .rst_n(rst_n), .start(start[2]), .op(op),
      .a(a_drv[7:0]), .b(b_drv[7:0]), .cin(cin), .sat(sat),
      .busy(busy[2]), .done(done[2]), .result(r2), .carry(carry[2]),
      .overflow(ovf[2]), .zero(zero[2]), .negative(neg[2]));

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: true integer arithmetic, then wrap / saturate to w bits.
   function automatic exp_t model(input logic [1:0] o, input logic [31:0] a,
                                  input logic [31:0] b, input logic ci_in,
                                  input logic s, input int w);
      exp_t r;
      logic [63:0] mask, aa, bb, ci, full, rv;
      longint      sa, sb, tv, maxp, minn;
      mask = (64'd1 << w) - 64'd1;
      aa   = 64'(a) & mask;
      bb   = 64'(b) & mask;
      ci   = o[1] ? 64'(ci_in) : 64'd0;
      sa   = (aa >= (64'd1 << (w-1))) ? $signed(aa) - $signed(64'd1 << w) : $signed(aa);
      sb   = (bb >= (64'd1 << (w-1))) ? $signed(bb) - $signed(64'd1 << w) : $signed(bb);
      maxp = $signed((64'd1 << (w-1)) - 64'd1);
      minn = -maxp - 1;
      if (!o[0]) begin
         full    = aa + bb + ci;
         r.carry = full[w];
         tv      = sa + sb + $signed(ci);
      end else begin
         r.carry = (aa < bb + ci);
         full    = aa - bb - ci;
         tv      = sa - sb - $signed(ci);
      end
      r.ovf = (tv > maxp) || (tv < minn);
      if (s && r.ovf) rv = (tv > maxp) ? $unsigned(maxp) : ($unsigned(minn) & mask);
      else            rv = full & mask;
      r.res  = rv[31:0];
      r.zero = (rv == 64'd0);
      r.neg  = rv[w-1];
      return r;
   endfunction

   // Issue one op to the instances in smask; optionally re-pulse start
   // mid-RUN with different operands (must be ignored).
   task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic ci, input logic s, input logic [2:0] smask, input bit poke);
      exp_t ex [3];
      bit   seen [3];
      int   lat [3];
      for (int i = 0; i < 3; i++) begin
         ex[i]   = model(o, a, b, ci, s, wid[i]);
         seen[i] = 1'b0;
         lat[i]  = 0;
      end
      @(negedge clk);
      op = o; a_drv = a; b_drv = b; cin = ci; sat = s; start = smask;
      @(negedge clk);
      start = 3'b000;
      for (int i = 0; i < 3; i++) begin
         if (smask[i]) begin
            chk($sformatf("busy_after_start_w%0d", wid[i]), 64'(busy[i]), 64'd1);
            chk($sformatf("held_at_start_w%0d", wid[i]), 64'(res[i]), 64'(prev_res[i]));
         end
      end
      for (int e = 2; e <= 12; e++) begin
         @(negedge clk);
         for (int i = 0; i < 3; i++) begin
            if (smask[i]) begin
               if (seen[i] && e == lat[i] + 1) begin
                  chk($sformatf("done_pulse_w%0d", wid[i]), 64'(done[i]), 64'd0);
                  chk($sformatf("res_hold_w%0d", wid[i]), 64'(res[i]), 64'(ex[i].res));
               end else if (!seen[i] && done[i]) begin
                  seen[i] = 1'b1;
                  lat[i]  = e;
                  chk($sformatf("latency_w%0d", wid[i]), 64'(e), 64'(lat_exp[i]));
                  chk($sformatf("busy_at_done_w%0d", wid[i]), 64'(busy[i]), 64'd0);
                  chk($sformatf("result_w%0d", wid[i]), 64'(res[i]), 64'(ex[i].res));
                  chk($sformatf("flags_w%0d", wid[i]),
                      64'({carry[i], ovf[i], zero[i], neg[i]}),
                      64'({ex[i].carry, ex[i].ovf, ex[i].zero, ex[i].neg}));
               end
            end
         end
         if (poke && e == 2) begin
            a_drv = 32'd9; b_drv = 32'd9; start = smask & 3'b011;
         end
         if (poke && e == 3) start = 3'b000;
      end
      for (int i = 0; i < 3; i++) begin
         if (smask[i]) begin
            if (!seen[i]) chk($sformatf("no_done_w%0d", wid[i]), 64'd0, 64'd1);
            prev_res[i] = ex[i].res;
         end
      end
   endtask

   // Second start on the 16/4 instance asserted in its done cycle.
   task automatic b2b_test(input logic [31:0] a1, input logic [31:0] b1,
                           input logic [31:0] a2, input logic [31:0] b2);
      exp_t e1, e2;
      int   got = 0;
      int   t1  = 0;
      e1 = model(c_ADD, a1, b1, 1'b0, 1'b0, 16);
      e2 = model(c_SUB, a2, b2, 1'b0, 1'b0, 16);
      @(negedge clk);
      op = c_ADD; a_drv = a1; b_drv = b1; cin = 1'b0; sat = 1'b0; start = 3'b001;
      @(negedge clk);
      start = 3'b000;
      for (int e = 2; e <= 14; e++) begin
         @(negedge clk);
         if (got == 1 && e == t1 + 1) begin
            start = 3'b000;
            chk("b2b_busy_no_gap", 64'(busy[0]), 64'd1);
         end
         if (done[0]) begin
            if (got == 0) begin
               chk("b2b_lat1", 64'(e), 64'd5);
               chk("b2b_res1", 64'(res[0]), 64'(e1.res));
               op = c_SUB; a_drv = a2; b_drv = b2; start = 3'b001;
               got = 1;
               t1  = e;
            end else if (got == 1) begin
               chk("b2b_lat2", 64'(e - t1), 64'd5);
               chk("b2b_res2", 64'(res[0]), 64'(e2.res));
               got = 2;
            end
         end
      end
      chk("b2b_both_done", 64'(got), 64'd2);
      prev_res[0] = e2.res;
   endtask

   // Assert reset during the second RUN cycle; outputs clear at once and
   // the aborted op never signals done.
   task automatic reset_test();
      int dcount = 0;
      @(negedge clk);
      op = c_ADD; a_drv = 32'h0000_00FF; b_drv = 32'h0000_0001; sat = 1'b0; start = 3'b111;
      @(negedge clk);
      start = 3'b000;
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("rst_ctl_w%0d", wid[i]),
             64'({busy[i], done[i], carry[i], ovf[i], zero[i], neg[i]}), 64'd0);
         chk($sformatf("rst_res_w%0d", wid[i]), 64'(res[i]), 64'd0);
         prev_res[i] = 32'd0;
      end
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (done != 3'b000) dcount++;
      end
      chk("no_done_after_abort", 64'(dcount), 64'd0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      rst_n = 1'b0; start = 3'b000; op = c_ADD;
      a_drv = '0; b_drv = '0; cin = 1'b0; sat = 1'b0;
      for (int i = 0; i < 3; i++) prev_res[i] = 32'd0;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reset_ctl_w%0d", wid[i]),
             64'({busy[i], done[i], carry[i], ovf[i], zero[i], neg[i]}), 64'd0);
         chk($sformatf("reset_res_w%0d", wid[i]), 64'(res[i]), 64'd0);
      end
      rst_n = 1'b1;

      run_op(c_ADD, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b0, 3'b111, 1'b0);
      run_op(c_ADD, 32'h0000_7FFF, 32'h0000_0001, 1'b0, 1'b1, 3'b111, 1'b0);
      run_op(c_SUB, 32'h0000_8000, 32'h0000_0001, 1'b0, 1'b1, 3'b111, 1'b0);
      run_op(c_SUB, 32'h0000_0000, 32'h0000_0001, 1'b0, 1'b0, 3'b111, 1'b0);
      run_op(c_SUB, 32'h0000_0005, 32'h0000_0005, 1'b0, 1'b0, 3'b111, 1'b0);
      run_op(c_ADC, 32'h0000_FFFF, 32'h0000_0000, 1'b1, 1'b0, 3'b111, 1'b0);
      run_op(c_SBB, 32'h0000_0000, 32'h0000_0000, 1'b1, 1'b0, 3'b111, 1'b0);
      run_op(c_ADC, 32'h0000_1234, 32'h0000_4321, 1'b0, 1'b0, 3'b111, 1'b0);
      run_op(c_ADD, 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b1, 3'b111, 1'b0);
      run_op(c_SUB, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1, 3'b111, 1'b0);
      run_op(c_ADD, 32'h0000_0001, 32'h0000_0001, 1'b0, 1'b0, 3'b011, 1'b1);
      b2b_test(32'h0000_1000, 32'h0000_0234, 32'h0000_0010, 32'h0000_0020);
      reset_test();
      run_op(c_ADD, 32'h0000_1234, 32'h0000_1111, 1'b0, 1'b0, 3'b111, 1'b0);

      for (int k = 0; k < 40; k++) begin
         run_op(2'($urandom_range(0, 3)), $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'b111, 1'b0);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
